ika87ad_addr_gen: RTL and testbench

//  Parametrised address-pointer bank for the IKA87AD core: NPTR pointer registers (ptr0 = PC by convention),

---
 rtl/ika87ad_addr_gen.sv | 125 ++++++++++++
 tb/tb_ika87ad_addr_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ika87ad_addr_gen.sv
// Address-pointer bank for the IKA87AD core: NPTR pointers with load, clear and directional auto-step.
// Define IKA87AD_ADDR_REGOUT_EN to register o_ADDR (one emuclk later) instead of a combinational mux.
module ika87ad_addr_gen #(
  parameter int AW = 16,
  parameter int NPTR = 4,
  parameter logic [NPTR-1:0] RD4_STEP_MASK = 4'b0001,
  parameter logic [NPTR-1:0] RD3_STEP_MASK = 4'b1111,
  parameter logic [NPTR-1:0] EOI_CLR_MASK  = 4'b0100,
  localparam int IW = $clog2(NPTR)
) (
  input  logic          i_EMUCLK,
  input  logic          i_MRST_n,
  input  logic          i_CYCLE_TICK,
  input  logic [1:0]    i_ACC_TYPE,
  input  logic          i_WR_EN,
  input  logic [IW-1:0] i_WR_SEL,
  input  logic [AW-1:0] i_WR_DATA,
  input  logic          i_SRC_VLD,
  input  logic [IW-1:0] i_SRC_SEL,
  input  logic          i_SRC_DEC,
  input  logic          i_EOI,
  output logic [AW-1:0] o_ADDR,
  output logic [IW-1:0] o_SRC,
  output logic          o_WRAP
);

  localparam logic [IW:0] NPTR_W = (IW+1)'(NPTR);

  logic [AW-1:0] ptr_q [NPTR];
  logic [AW-1:0] ptr_d [NPTR];
  logic [IW-1:0] src_q, src_d;
  logic [NPTR-1:0] dec_q, dec_d;
  logic wrap_q, wrap_d;
  logic [NPTR-1:0] step_mask;
  logic wr_valid, sel_valid, src_valid;
  logic [AW-1:0] addr_mux;

  assign wr_valid  = ({1'b0, i_WR_SEL} < NPTR_W);
  assign sel_valid = ({1'b0, i_SRC_SEL} < NPTR_W);
  assign src_valid = ({1'b0, src_q} < NPTR_W);

  always_comb begin
    step_mask = '0;
    case (i_ACC_TYPE)
      2'b01:   step_mask = RD4_STEP_MASK;
      2'b10,
      2'b11:   step_mask = RD3_STEP_MASK;
      default: step_mask = '0;
    endcase
  end

  // Per-pointer priority is load > EOI clear > auto-step > hold; stepping uses the pre-tick source and direction.
  always_comb begin
    for (int k = 0; k < NPTR; k++) ptr_d[k] = ptr_q[k];
    src_d  = src_q;
    dec_d  = dec_q;
    wrap_d = 1'b0;
    if (i_CYCLE_TICK) begin
      for (int k = 0; k < NPTR; k++) begin
        if (i_WR_EN && wr_valid && (i_WR_SEL == IW'(k))) begin
          ptr_d[k] = i_WR_DATA;
        end else if (i_EOI && EOI_CLR_MASK[k]) begin
          ptr_d[k] = '0;
        end else if (!i_SRC_VLD && (src_q == IW'(k)) && step_mask[k]) begin
          if (dec_q[k]) begin
            ptr_d[k] = ptr_q[k] - AW'(1);
            if (ptr_q[k] == '0) wrap_d = 1'b1;
          end else begin
            ptr_d[k] = ptr_q[k] + AW'(1);
            if (ptr_q[k] == '1) wrap_d = 1'b1;
          end
        end
      end

      // A PC load without a source change sends fetch back to ptr0.
      if (i_EOI) begin
        src_d = '0;
      end else if (i_SRC_VLD) begin
        if (sel_valid) src_d = i_SRC_SEL;
      end else if (i_WR_EN && (i_WR_SEL == '0)) begin
        src_d = '0;
      end

      if (i_EOI) begin
        dec_d = '0;
      end else if (i_SRC_VLD && sel_valid) begin
        for (int k = 0; k < NPTR; k++)
          if (i_SRC_SEL == IW'(k)) dec_d[k] = i_SRC_DEC;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      for (int k = 0; k < NPTR; k++) ptr_q[k] <= '0;
      src_q  <= '0;
      dec_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      for (int k = 0; k < NPTR; k++) ptr_q[k] <= ptr_d[k];
      src_q  <= src_d;
      dec_q  <= dec_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_mux = src_valid ? ptr_q[src_q] : '0;

`ifdef IKA87AD_ADDR_REGOUT_EN
  logic [AW-1:0] addr_q;

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) addr_q <= '0;
    else           addr_q <= addr_mux;
  end

  assign o_ADDR = addr_q;
`else
  assign o_ADDR = addr_mux;
`endif

  assign o_SRC  = src_q;
  assign o_WRAP = wrap_q;

endmodule

// File: tb/tb_ika87ad_addr_gen.sv
// Directed, table-driven bench for ika87ad_addr_gen in its default (combinational o_ADDR) build.
module tb_ika87ad_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [1:0]  acc;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic        src_vld;
  logic [1:0]  src_sel;
  logic        src_dec;
  logic        eoi;
  logic [15:0] addr;
  logic [1:0]  src;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        tick;
    logic [1:0]  acc;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data;
    logic        src_vld;
    logic [1:0]  src_sel;
    logic        src_dec;
    logic        eoi;
    logic [15:0] e_addr;
    logic [1:0]  e_src;
    logic        e_wrap;
  } vec_t;

  vec_t vecs[$];

  ika87ad_addr_gen dut (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_CYCLE_TICK(tick), .i_ACC_TYPE(acc),
    .i_WR_EN(wr_en), .i_WR_SEL(wr_sel), .i_WR_DATA(wr_data),
    .i_SRC_VLD(src_vld), .i_SRC_SEL(src_sel), .i_SRC_DEC(src_dec), .i_EOI(eoi),
    .o_ADDR(addr), .o_SRC(src), .o_WRAP(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic t, logic [1:0] a, logic we, logic [1:0] ws, logic [15:0] wd,
                              logic sv, logic [1:0] ss, logic sd, logic e,
                              logic [15:0] ea, logic [1:0] es, logic ew);
    vec_t v;
    v.tick = t; v.acc = a; v.wr_en = we; v.wr_sel = ws; v.wr_data = wd;
    v.src_vld = sv; v.src_sel = ss; v.src_dec = sd; v.eoi = e;
    v.e_addr = ea; v.e_src = es; v.e_wrap = ew;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    tick = v.tick; acc = v.acc; wr_en = v.wr_en; wr_sel = v.wr_sel; wr_data = v.wr_data;
    src_vld = v.src_vld; src_sel = v.src_sel; src_dec = v.src_dec; eoi = v.eoi;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] e_addr,
                             input logic [1:0] e_src, input logic e_wrap);
    checks++;
    if (addr !== e_addr) begin
      errors++;
      $display("[TB] FAIL %s addr: got %h expected %h", name, addr, e_addr);
    end
    checks++;
    if (src !== e_src) begin
      errors++;
      $display("[TB] FAIL %s src: got %0d expected %0d", name, src, e_src);
    end
    checks++;
    if (wrap !== e_wrap) begin
      errors++;
      $display("[TB] FAIL %s wrap: got %b expected %b", name, wrap, e_wrap);
    end
  endtask

  // One table row per emuclk: drive on the falling edge, check just after the rising edge.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(name, v.e_addr, v.e_src, v.e_wrap);
  endtask

  initial begin
    //        tick acc we ws wdata     sv ss sd eoi  addr      src wrap
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0001, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(0, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 2'd0, 1, 1, 16'h0000, 0, 0, 0, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 1, 1));
    vecs.push_back(mk(1, 2'd3, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFE, 1, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 1, 2, 1, 0, 16'h0000, 2, 0));
    vecs.push_back(mk(1, 2'd2, 1, 2, 16'h1234, 0, 0, 0, 1, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 1, 2, 0, 0, 16'h1234, 2, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 16'h0000, 1, 2, 0, 0, 16'h0000, 2, 0));
    vecs.push_back(mk(1, 2'd2, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0001, 2, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0001, 2, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0001, 2, 0));
    vecs.push_back(mk(1, 2'd0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 16'hFFFF, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 2'd1, 1, 0, 16'h00A5, 0, 0, 0, 0, 16'h00A5, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 0, 16'h0000, 1, 1, 0, 1, 16'h00A5, 0, 0));

    rst_n = 1'b0;
    applyStimulus(mk(0, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0));
    #12;
    checkOutput("reset", 16'h0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Leave ptr1 non-zero and active, then reset asynchronously between edges.
    run_vec(mk(1, 2'd0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'hFFFE, 1, 0), "pre_reset_sel1");
    @(negedge clk);
    applyStimulus(mk(1, 2'd1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 16'h0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 16'h0000, 2'd0, 1'b0);
    @(negedge clk);
    applyStimulus(mk(0, 2'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0));
    rst_n = 1'b1;
    run_vec(mk(1, 2'd0, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 0), "post_reset_ptr1");
    run_vec(mk(1, 2'd0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0), "post_reset_ptr0");
    run_vec(mk(1, 2'd2, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0001, 0, 0), "post_reset_step");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
